// File: rtl/game_pkg.sv
// Shared game-logic constants, board-select FSM states and source indices.
package game_pkg;

    localparam int BOARD_ROWS = 4;
    localparam int BOARD_COLS = 4;
    localparam int CELL_W     = 12;

    localparam int SRC_LEFT  = 0;
    localparam int SRC_RIGHT = 1;
    localparam int SRC_UP    = 2;
    localparam int SRC_DOWN  = 3;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        WRITE
    } bsel_state_t;

endpackage

// File: rtl/board_select_reg_if.sv
// Request/response bundle of the board selector.
// BOARD_UNDO_EN adds the undo request and undo_avail status.
interface board_select_reg_if #(
    parameter int NUM_SRC = 4,
    parameter int ROWS    = game_pkg::BOARD_ROWS,
    parameter int COLS    = game_pkg::BOARD_COLS,
    parameter int CELL_W  = game_pkg::CELL_W
);
    localparam int SEL_W = $clog2(NUM_SRC);

    logic [CELL_W-1:0] boards [NUM_SRC][ROWS][COLS];
    logic [SEL_W-1:0]  sel;
    logic              req;
    logic              clear;
    logic              ready;
    logic              done;
    logic              changed;
    logic              err;
    logic [CELL_W-1:0] board [ROWS][COLS];
`ifdef BOARD_UNDO_EN
    logic              undo;
    logic              undo_avail;
`endif

    modport master (
        output boards, sel, req, clear,
`ifdef BOARD_UNDO_EN
        output undo,
        input  undo_avail,
`endif
        input  ready, done, changed, err, board
    );

    modport slave (
        input  boards, sel, req, clear,
`ifdef BOARD_UNDO_EN
        input  undo,
        output undo_avail,
`endif
        output ready, done, changed, err, board
    );

endinterface

// File: rtl/board_select_reg_neq.sv
// Combinational board compare: neq is set when any cell of a and b differs.
module board_neq #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int CELL_W = 12
) (
    input  logic [CELL_W-1:0] a [ROWS][COLS],
    input  logic [CELL_W-1:0] b [ROWS][COLS],
    output logic              neq
);

    always_comb begin
        neq = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                neq = neq | (a[r][c] != b[r][c]);
            end
        end
    end

endmodule

// File: rtl/board_select_reg.sv
// Clocked N-source board selector holding the current game board.
// Optional undo support under BOARD_UNDO_EN.
module board_select_reg #(
    parameter int NUM_SRC = 4,
    parameter int ROWS    = game_pkg::BOARD_ROWS,
    parameter int COLS    = game_pkg::BOARD_COLS,
    parameter int CELL_W  = game_pkg::CELL_W
) (
    input logic               clk,
    input logic               rst_n,
    board_select_reg_if.slave bus
);
    import game_pkg::*;

    bsel_state_t       state;
    logic              ready;
    logic              done;
    logic              changed;
    logic              err;
    logic              diff;
    logic              stage_diff;
    logic              board_nz;
    logic [CELL_W-1:0] board_q [ROWS][COLS];
    logic [CELL_W-1:0] stage   [ROWS][COLS];
    logic [CELL_W-1:0] zero_b  [ROWS][COLS];

    assign zero_b      = '{default: '0};
    assign bus.ready   = ready;
    assign bus.done    = done;
    assign bus.changed = changed;
    assign bus.err     = err;
    assign bus.board   = board_q;

    board_neq #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W)) u_cmp (
        .a(stage), .b(board_q), .neq(stage_diff)
    );

    board_neq #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W)) u_nz (
        .a(board_q), .b(zero_b), .neq(board_nz)
    );

`ifdef BOARD_UNDO_EN
    logic              undo_avail;
    logic              undo_diff;
    logic [CELL_W-1:0] prev [ROWS][COLS];

    assign bus.undo_avail = undo_avail;

    board_neq #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W)) u_undo (
        .a(prev), .b(board_q), .neq(undo_diff)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            changed <= 1'b0;
            err     <= 1'b0;
            diff    <= 1'b0;
            board_q <= '{default: '0};
            stage   <= '{default: '0};
`ifdef BOARD_UNDO_EN
            prev       <= '{default: '0};
            undo_avail <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    // ready low here only for the cycle after clear/undo
                    if (!ready) begin
                        ready <= 1'b1;
                    end else if (bus.clear) begin
                        board_q <= zero_b;
                        done    <= 1'b1;
                        changed <= board_nz;
                        ready   <= 1'b0;
`ifdef BOARD_UNDO_EN
                        undo_avail <= 1'b0;
                    end else if (bus.undo) begin
                        if (undo_avail) begin
                            board_q    <= prev;
                            undo_avail <= 1'b0;
                            done       <= 1'b1;
                            changed    <= undo_diff;
                            ready      <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
`endif
                    end else if (bus.req) begin
                        if (int'(bus.sel) < NUM_SRC) begin
                            stage <= bus.boards[bus.sel];
                            ready <= 1'b0;
                            state <= CMP;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                CMP: begin
                    diff    <= stage_diff;
                    done    <= 1'b1;
                    changed <= stage_diff;
                    state   <= WRITE;
                end
                WRITE: begin
                    if (diff) begin
                        board_q <= stage;
`ifdef BOARD_UNDO_EN
                        prev       <= board_q;
                        undo_avail <= 1'b1;
`endif
                    end
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_select_reg.sv
// Directed bench for board_select_reg (3 sources, 4x4x12 board).
// Undo scenario is built when BOARD_UNDO_EN is defined.
module tb_board_select_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    board_select_reg_if #(.NUM_SRC(3)) bus ();

    board_select_reg #(.NUM_SRC(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // step past the next rising edge; outputs are sampled 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.boards = '{default: '0};
        bus.sel    = '0;
        bus.req    = 1'b0;
        bus.clear  = 1'b0;
`ifdef BOARD_UNDO_EN
        bus.undo   = 1'b0;
`endif
        #12;
        chk("rst_ready", 32'(bus.ready), 1);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_board", 32'(bus.board[0][0]), 0);
        rst_n = 1'b1;
        tick();

        // 1: reset while in CMP aborts without commit
        bus.boards[1][0][0] = 12'h0AA;
        bus.sel = 2'd1;
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        chk("t1_cmp_ready", 32'(bus.ready), 0);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_ready", 32'(bus.ready), 1);
        chk("t1_rst_done", 32'(bus.done), 0);
        chk("t1_rst_board", 32'(bus.board[0][0]), 0);
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("t1_no_commit", 32'(bus.board[0][0]), 0);
        chk("t1_no_done", 32'(bus.done), 0);

        // 2: differing board from source 2
        bus.boards[2][0][0] = 12'h002;
        bus.sel = 2'd2;
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        chk("t2_p1_ready", 32'(bus.ready), 0);
        chk("t2_p1_done", 32'(bus.done), 0);
        tick();
        chk("t2_p2_done", 32'(bus.done), 1);
        chk("t2_p2_changed", 32'(bus.changed), 1);
        chk("t2_p2_ready", 32'(bus.ready), 0);
        tick();
        chk("t2_p3_ready", 32'(bus.ready), 1);
        chk("t2_p3_done", 32'(bus.done), 0);
        chk("t2_board00", 32'(bus.board[0][0]), 32'h2);

        // 3: identical board; candidate edits after accept are ignored
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        bus.boards[2][0][0] = 12'h005;
        tick();
        chk("t3_done", 32'(bus.done), 1);
        chk("t3_changed", 32'(bus.changed), 0);
        tick();
        chk("t3_ready", 32'(bus.ready), 1);
        chk("t3_board00", 32'(bus.board[0][0]), 32'h2);

        // 4: out-of-range select, then req held during CMP
        bus.sel = 2'd3;
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        chk("t4_err", 32'(bus.err), 1);
        chk("t4_err_done", 32'(bus.done), 0);
        chk("t4_err_ready", 32'(bus.ready), 1);
        tick();
        chk("t4_err_clr", 32'(bus.err), 0);
        chk("t4_board00", 32'(bus.board[0][0]), 32'h2);
        bus.boards[1][0][0] = 12'h000;
        bus.boards[1][1][1] = 12'h007;
        bus.sel = 2'd1;
        bus.req = 1'b1;
        tick();
        bus.sel = 2'd0;
        tick();
        chk("t4_done", 32'(bus.done), 1);
        chk("t4_changed", 32'(bus.changed), 1);
        bus.req = 1'b0;
        tick();
        chk("t4_ready", 32'(bus.ready), 1);
        chk("t4_board11", 32'(bus.board[1][1]), 32'h7);
        chk("t4_board00b", 32'(bus.board[0][0]), 0);
        tick();
        chk("t4_no_requeue", 32'(bus.done), 0);

        // 5: clear and req together; clear wins
        bus.clear = 1'b1;
        bus.req = 1'b1;
        bus.sel = 2'd2;
        tick();
        bus.clear = 1'b0;
        bus.req = 1'b0;
        chk("t5_done", 32'(bus.done), 1);
        chk("t5_changed", 32'(bus.changed), 1);
        chk("t5_ready", 32'(bus.ready), 0);
        chk("t5_board11", 32'(bus.board[1][1]), 0);
        tick();
        chk("t5_ready_back", 32'(bus.ready), 1);
        chk("t5_done_clr", 32'(bus.done), 0);
        tick();
        chk("t5_req_dropped", 32'(bus.ready), 1);
        chk("t5_board00", 32'(bus.board[0][0]), 0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("t5_zero_done", 32'(bus.done), 1);
        chk("t5_zero_changed", 32'(bus.changed), 0);
        tick();

`ifdef BOARD_UNDO_EN
        // 6: commit A then B, undo back to A, second undo errors
        chk("t6_avail0", 32'(bus.undo_avail), 0);
        bus.boards[0] = '{default: '0};
        bus.boards[0][0][0] = 12'h00A;
        bus.sel = 2'd0;
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        tick();
        tick();
        bus.boards[1] = '{default: '0};
        bus.boards[1][0][0] = 12'h00B;
        bus.sel = 2'd1;
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        tick();
        tick();
        chk("t6_board_b", 32'(bus.board[0][0]), 32'hB);
        chk("t6_avail1", 32'(bus.undo_avail), 1);
        bus.undo = 1'b1;
        tick();
        bus.undo = 1'b0;
        chk("t6_undo_done", 32'(bus.done), 1);
        chk("t6_undo_changed", 32'(bus.changed), 1);
        chk("t6_undo_board", 32'(bus.board[0][0]), 32'hA);
        chk("t6_undo_avail", 32'(bus.undo_avail), 0);
        tick();
        bus.undo = 1'b1;
        tick();
        bus.undo = 1'b0;
        chk("t6_undo2_err", 32'(bus.err), 1);
        chk("t6_undo2_done", 32'(bus.done), 0);
        chk("t6_undo2_board", 32'(bus.board[0][0]), 32'hA);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_select_reg.md
Name: board_select_reg

Overview:
- Parametrised N-source board selector with a registered "current board" for the game-logic datapath.
- On a request it:
  - picks one of NUM_SRC candidate boards (move-left/right/up/down results, spawn result, …);
  - compares the candidate with the current board;
  - commits it only if it differs.
- Reports whether the board changed. Game FSM uses this to decide tile spawn and move legality.
- Replaces the fixed 2:1 combinational matrix select with a clocked, handshaked stage.

Parameters:
- NUM_SRC, 4, number of candidate boards (≥2).
- ROWS, 4, board rows.
- COLS, 4, board columns.
- CELL_W, 12, bits per cell.
- SEL_W, $clog2(NUM_SRC), select width (derived, do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- boards  input  [CELL_W-1:0] x [NUM_SRC-1:0][ROWS-1:0][COLS-1:0] (unpacked)  candidate boards.
- sel  input  SEL_W  candidate index, sampled on accept.
- req  input  1  load request.
- clear  input  1  synchronous board clear (new game).
- ready  output  1  high in IDLE; req accepted when req&&ready.
- done  output  1  one-cycle pulse at end of each accepted operation.
- changed  output  1  valid with done: committed board differed from previous.
- err  output  1  one-cycle pulse: rejected request.
- board  output  [CELL_W-1:0] x [ROWS-1:0][COLS-1:0] (unpacked)  current board register.

Behaviour:
- Reset (rst_n=0, async):
  - board all zero, ready=1, done=0, changed=0, err=0, state=IDLE.
  - Staging register cleared.
  - Reset mid-operation aborts the operation; no partial commit.
- FSM states: IDLE, CMP, WRITE.
  - IDLE: ready=1. On req (clear low) and sel<NUM_SRC:
    - stage <= boards[sel] (sampled that edge);
    - go to CMP.
  - IDLE, req with sel≥NUM_SRC:
    - err pulses next cycle; stay IDLE; board unchanged; no done.
  - CMP: ready=0. Registers diff = (stage != board), cell-wise over all ROWS*COLS*CELL_W bits; go to WRITE.
  - WRITE:
    - if diff, board <= stage;
    - done=1 and changed=diff for exactly this cycle;
    - go to IDLE.
- Latency: accept edge at cycle 0 → done high in cycle 2 → ready high again in cycle 3. Throughput is one request per 3 cycles.
- Candidate inputs are sampled only at accept; later changes are ignored.
- clear:
  - Acts in IDLE only, with priority over req: board <= 0, done pulses, changed = (old board != 0), ready drops for that cycle.
  - clear in CMP/WRITE is ignored; the requester must hold it until ready.
- req while ready=0 is ignored (not queued).
- done and err are never high in the same cycle.
- Outputs done, changed and err are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: BOARD_UNDO_EN.
- Defined:
  - Adds input undo, output undo_avail, and a prev register (ROWS×COLS×CELL_W, reset 0; undo_avail resets 0).
  - Every WRITE with diff=1 does prev <= old board and undo_avail <= 1.
  - Undo in IDLE (priority below clear, above req) with undo_avail=1:
    - board <= prev, undo_avail <= 0;
    - done pulses next cycle with changed = (prev != board).
  - Undo with undo_avail=0 produces an err pulse.
  - clear sets undo_avail <= 0.
- Undefined: no undo port, prev register or undo_avail exist; behaviour is exactly as above.

Decomposition:
- Package game_pkg holds:
  - default constants BOARD_ROWS=4, BOARD_COLS=4, CELL_W=12;
  - state enum bsel_state_t {IDLE, CMP, WRITE};
  - source index constants SRC_LEFT=0, SRC_RIGHT=1, SRC_UP=2, SRC_DOWN=3.
- One sub-module, board_neq: parametrised combinational reduction of two boards to a 1-bit "differs" flag. It is reused for the CMP diff, the clear changed flag, and the undo changed flag.

Test Plan:
1. Reset: assert rst_n=0 mid-CMP after loading → board=0, ready=1, done=0, no commit after release.
2. Load a differing board: board=0, boards[2] with cell[0][0]=12'h002, sel=2, req one cycle → done at +2 with changed=1, board[0][0]=2, ready back at +3.
3. Load an identical board: repeat scenario 2 with the same sel → done at +2, changed=0, board unchanged.
4. Invalid select: NUM_SRC=3, sel=3, req → err pulse at +1, no done, board unchanged; req during CMP ignored.
5. Clear vs req same cycle: board non-zero, clear=1 and req=1 → board=0, done with changed=1, req dropped.
6. (BOARD_UNDO_EN) Commit two different boards A→B, then undo → board=A, changed=1, undo_avail=0; second undo → err pulse.
